frame_config_mem_dbuf: RTL and testbench
========================================

Name: frame_config_mem_dbuf

Overview:
Clocked, parametrised, double-buffered tile configuration memory.
- Frames arrive on the column frame bus (FrameData plus a one-hot FrameStrobe) and are written into a shadow bank.
- A commit request copies the complete shadow bank atomically into the active bank, which drives the tile's ConfigBits.
- Sits between the column frame distribution and tile switch-matrix/BEL config inputs, so a tile is reconfigured without glitching partially-loaded bits.

Parameters:
MaxFramesPerCol, 32, width of FrameStrobe; upper bound on frame count
FrameBitsPerRow, 32, width of FrameData (bits per frame)
NoConfigBits, 160, number of config bits held; NumFrames = ceil(NoConfigBits/FrameBitsPerRow), must be <= MaxFramesPerCol (elaboration error otherwise)

Ports:
CLK  input  1  configuration clock, rising edge
resetn  input  1  asynchronous, active-low reset
FrameData  input  FrameBitsPerRow  frame payload
FrameStrobe  input  MaxFramesPerCol  one-hot frame write select, sampled each CLK edge
CommitReq  input  1  single-cycle request to copy shadow to active
ClearErr  input  1  clears sticky StrobeErr
ConfigBits  output  NoConfigBits  active configuration
ConfigBits_N  output  NoConfigBits  bitwise inverse of ConfigBits
FramesLoaded  output  MaxFramesPerCol  mask of shadow frames written since last commit; bits >= NumFrames always 0
CommitDone  output  1  one-cycle pulse after a successful commit
CommitErr  output  1  one-cycle pulse when a commit is rejected for incomplete load
StrobeErr  output  1  sticky: illegal strobe seen
ReadReq  input  1  (READBACK_EN only) readback request
ReadAddr  input  $clog2(MaxFramesPerCol)  (READBACK_EN only) frame index
ReadData  output  FrameBitsPerRow  (READBACK_EN only) readback word
ReadValid  output  1  (READBACK_EN only) readback qualifier

Behaviour:
- Reset (async assert, sync-to-CLK deassert not required internally):
  - shadow = 0, active = 0, so ConfigBits = 0 and ConfigBits_N = all 1s.
  - FramesLoaded = 0; CommitDone, CommitErr, StrobeErr = 0.
  - ReadData = 0, ReadValid = 0.
- Bit mapping: frame f, FrameData[b] maps to config bit f*FrameBitsPerRow + b. The last frame stores only its low NoConfigBits - (NumFrames-1)*FrameBitsPerRow bits; upper bits are discarded.
- ConfigBits_N is always ~ConfigBits (same register, no extra latency).
- Write path:
  - Exactly one FrameStrobe bit f set, with f < NumFrames: shadow frame f <= FrameData at the edge, and FramesLoaded[f] <= 1. Rewriting a loaded frame overwrites it; the mask bit stays 1.
  - All-zero FrameStrobe: no action.
  - Multi-hot strobe, or one-hot with f >= NumFrames: no write, StrobeErr <= 1.
  - StrobeErr clears only on ClearErr. If ClearErr and a new error occur in the same cycle, the error wins.
- Commit FSM, states IDLE and DONE:
  - IDLE, CommitReq=1, FramesLoaded covers all NumFrames, FrameStrobe=0:
    - active <= shadow at that edge, so ConfigBits changes in the next cycle.
    - FramesLoaded <= 0; go to DONE.
    - CommitDone=1 for exactly that next cycle; DONE then returns to IDLE.
  - IDLE, CommitReq=1, mask incomplete: no copy, mask kept, CommitErr=1 for one cycle.
  - CommitReq with FrameStrobe nonzero in the same cycle: the write/error proceeds, the commit is ignored, no CommitErr is raised, and the requester must retry.
  - CommitReq while in DONE: ignored, no error.
  - Shadow is not cleared by commit; its contents persist for a subsequent partial update, which still needs a full mask to commit.
- Reset mid-load or mid-commit clears both banks; no partial active update is ever visible.

Optional Feature:
- Macro READBACK_EN.
- Defined:
  - ReadReq=1 with ReadAddr < NumFrames: next cycle ReadData = active frame ReadAddr, zero-extended for the last partial frame, and ReadValid=1.
  - ReadAddr >= NumFrames: ReadData=0, ReadValid=1, StrobeErr <= 1.
  - ReadReq=0: ReadValid=0 and ReadData holds.
  - Readback in the commit-edge cycle returns pre-commit active data.
- Undefined: ReadReq, ReadAddr, ReadData and ReadValid ports are absent; no readback logic.

Test Plan:
- Reset with defaults -> ConfigBits=160'h0, ConfigBits_N=all 1s, FramesLoaded=0.
- Write frames 0..4 with 32'hA5A5_0000+f, then CommitReq -> CommitDone high for one cycle 1 cycle later; ConfigBits[31:0]=32'hA5A5_0000, ConfigBits[159:128]=32'hA5A5_0004; FramesLoaded=0.
- Write frames 0..3 only, then CommitReq -> CommitErr pulse; ConfigBits unchanged; FramesLoaded=32'h0000_000F.
- FrameStrobe=32'h0000_0003, then 32'h0000_0020 -> no shadow change, StrobeErr=1; ClearErr -> StrobeErr=0.
- Frame 2 write and CommitReq in the same cycle with mask full -> write lands in shadow, no commit, no CommitErr; retried CommitReq -> commit with new frame 2.
- READBACK_EN: after commit, ReadReq with ReadAddr=4 -> next cycle ReadValid=1, ReadData=32'hA5A5_0004; ReadAddr=7 -> ReadData=0, StrobeErr=1.

Source files
------------

// File: rtl/frame_config_mem_dbuf.sv
// -----------------------------------------------------------------------------
// frame_config_mem_dbuf
//
// Double-buffered tile configuration memory. Frames from the column frame bus
// are written into a shadow bank. A commit request copies the whole shadow bank
// into the active bank in one edge, so the tile never sees a half-loaded
// configuration.
//
// Optional feature macro: READBACK_EN (adds a registered readback port onto
// the active bank).
//
// Ports:
//   CLK           in   configuration clock, rising edge
//   resetn        in   asynchronous active-low reset
//   FrameData     in   frame payload (FrameBitsPerRow)
//   FrameStrobe   in   one-hot frame write select (MaxFramesPerCol)
//   CommitReq     in   single-cycle request: copy shadow -> active
//   ClearErr      in   clears sticky StrobeErr
//   ConfigBits    out  active configuration (NoConfigBits)
//   ConfigBits_N  out  bitwise inverse of ConfigBits
//   FramesLoaded  out  shadow frames written since last commit
//   CommitDone    out  one-cycle pulse after a successful commit
//   CommitErr     out  one-cycle pulse when a commit is rejected
//   StrobeErr     out  sticky illegal strobe / readback address flag
//   ReadReq       in   (READBACK_EN) readback request
//   ReadAddr      in   (READBACK_EN) frame index to read
//   ReadData      out  (READBACK_EN) readback word, zero-extended
//   ReadValid     out  (READBACK_EN) readback qualifier
// -----------------------------------------------------------------------------
module frame_config_mem_dbuf #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 160
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       CommitReq,
  input  logic                       ClearErr,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NoConfigBits-1:0]    ConfigBits_N,
  output logic [MaxFramesPerCol-1:0] FramesLoaded,
  output logic                       CommitDone,
  output logic                       CommitErr,
  output logic                       StrobeErr
`ifdef READBACK_EN
  ,
  input  logic                               ReadReq,
  input  logic [$clog2(MaxFramesPerCol)-1:0] ReadAddr,
  output logic [FrameBitsPerRow-1:0]         ReadData,
  output logic                               ReadValid
`endif
);

  localparam int unsigned NumFrames =
    (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
  // Width actually stored for the final (possibly partial) frame.
  localparam int unsigned LastW = NoConfigBits - (NumFrames - 1) * FrameBitsPerRow;
  // Strobe bits that address a real frame.
  localparam logic [MaxFramesPerCol-1:0] FrameMask =
    {MaxFramesPerCol{1'b1}} >> (MaxFramesPerCol - NumFrames);

  if (NumFrames > MaxFramesPerCol) begin : g_cfg_check
    $error("frame_config_mem_dbuf: NumFrames exceeds MaxFramesPerCol");
  end

  typedef enum logic {
    S_IDLE,
    S_DONE
  } state_t;

  state_t                     r_state;
  logic [NoConfigBits-1:0]    r_shadow;
  logic [NoConfigBits-1:0]    r_active;
  logic [MaxFramesPerCol-1:0] r_loaded;
  logic                       r_commit_done;
  logic                       r_commit_err;
  logic                       r_strobe_err;

  logic                       w_strobe_nz;
  logic                       w_write;
  logic                       w_strobe_err;
  logic                       w_mask_full;
  logic                       w_read_err;
  logic [NoConfigBits-1:0]    w_shadow_next;

  // A write needs exactly one strobe bit, and that bit must name a real frame.
  assign w_strobe_nz  = |FrameStrobe;
  assign w_write      = $onehot(FrameStrobe) && ((FrameStrobe & ~FrameMask) == '0);
  assign w_strobe_err = w_strobe_nz && !w_write;
  assign w_mask_full  = (r_loaded == FrameMask);

  // Per-frame shadow update; the last frame keeps only its low LastW bits.
  for (genvar f = 0; f < NumFrames; f++) begin : g_frame
    localparam int unsigned Lo = f * FrameBitsPerRow;
    localparam int unsigned W  = (f == NumFrames - 1) ? LastW : FrameBitsPerRow;
    assign w_shadow_next[Lo +: W] =
      (w_write && FrameStrobe[f]) ? FrameData[W-1:0] : r_shadow[Lo +: W];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_active      <= '0;
      r_loaded      <= '0;
      r_commit_done <= 1'b0;
      r_commit_err  <= 1'b0;
      r_strobe_err  <= 1'b0;
    end else begin
      r_shadow      <= w_shadow_next;
      r_commit_done <= 1'b0;
      r_commit_err  <= 1'b0;

      if (w_write) begin
        r_loaded <= r_loaded | FrameStrobe;
      end

      // A fresh error takes priority over a simultaneous clear.
      if (w_strobe_err || w_read_err) begin
        r_strobe_err <= 1'b1;
      end else if (ClearErr) begin
        r_strobe_err <= 1'b0;
      end

      // Any strobe activity in the request cycle silently drops the commit;
      // the write and the clear of the mask can therefore never collide.
      case (r_state)
        S_IDLE: begin
          if (CommitReq && !w_strobe_nz) begin
            if (w_mask_full) begin
              r_active      <= r_shadow;
              r_loaded      <= '0;
              r_commit_done <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_commit_err  <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ConfigBits   = r_active;
  assign ConfigBits_N = ~r_active;
  assign FramesLoaded = r_loaded;
  assign CommitDone   = r_commit_done;
  assign CommitErr    = r_commit_err;
  assign StrobeErr    = r_strobe_err;

`ifdef READBACK_EN
  logic [FrameBitsPerRow-1:0] w_active_frame [NumFrames];
  logic [FrameBitsPerRow-1:0] w_read_word;
  logic [FrameBitsPerRow-1:0] r_read_data;
  logic                       r_read_valid;

  for (genvar f = 0; f < NumFrames; f++) begin : g_rd_frame
    localparam int unsigned Lo = f * FrameBitsPerRow;
    localparam int unsigned W  = (f == NumFrames - 1) ? LastW : FrameBitsPerRow;
    if (W == FrameBitsPerRow) begin : g_full
      assign w_active_frame[f] = r_active[Lo +: W];
    end else begin : g_part
      assign w_active_frame[f] = {{(FrameBitsPerRow - W){1'b0}}, r_active[Lo +: W]};
    end
  end

  always_comb begin
    w_read_word = '0;
    for (int unsigned f = 0; f < NumFrames; f++) begin
      if (32'(ReadAddr) == f) begin
        w_read_word = w_active_frame[f];
      end
    end
  end

  assign w_read_err = ReadReq && (32'(ReadAddr) >= NumFrames);

  // Reads sample r_active before any same-edge commit lands.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= ReadReq;
      if (ReadReq) begin
        r_read_data <= w_read_word;
      end
    end
  end

  assign ReadData  = r_read_data;
  assign ReadValid = r_read_valid;
`else
  assign w_read_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_config_mem_dbuf.sv
// -----------------------------------------------------------------------------
// tb_frame_config_mem_dbuf
//
// Directed bench for frame_config_mem_dbuf with default parameters
// (5 frames of 32 bits, 160 config bits). Build with +define+READBACK_EN to
// also exercise the readback port.
// -----------------------------------------------------------------------------
module tb_frame_config_mem_dbuf;

  localparam int MAXF = 32;
  localparam int FBR  = 32;
  localparam int NCB  = 160;

  logic            CLK;
  logic            resetn;
  logic [FBR-1:0]  FrameData;
  logic [MAXF-1:0] FrameStrobe;
  logic            CommitReq;
  logic            ClearErr;
  logic [NCB-1:0]  ConfigBits;
  logic [NCB-1:0]  ConfigBits_N;
  logic [MAXF-1:0] FramesLoaded;
  logic            CommitDone;
  logic            CommitErr;
  logic            StrobeErr;
`ifdef READBACK_EN
  logic            ReadReq;
  logic [4:0]      ReadAddr;
  logic [FBR-1:0]  ReadData;
  logic            ReadValid;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCB-1:0] exp_cfg;

  frame_config_mem_dbuf #(
    .MaxFramesPerCol(MAXF),
    .FrameBitsPerRow(FBR),
    .NoConfigBits   (NCB)
  ) u_dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .CommitReq   (CommitReq),
    .ClearErr    (ClearErr),
    .ConfigBits  (ConfigBits),
    .ConfigBits_N(ConfigBits_N),
    .FramesLoaded(FramesLoaded),
    .CommitDone  (CommitDone),
    .CommitErr   (CommitErr),
    .StrobeErr   (StrobeErr)
`ifdef READBACK_EN
    ,
    .ReadReq     (ReadReq),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [NCB-1:0] act, input logic [NCB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic write_frame(input int f, input logic [FBR-1:0] d);
    FrameStrobe = '0;
    FrameStrobe[f] = 1'b1;
    FrameData = d;
    step();
    FrameStrobe = '0;
    FrameData = '0;
  endtask

  task automatic chk_cfg(input string tag, input logic [NCB-1:0] exp);
    chk({tag, ".cfg"},   ConfigBits,   exp);
    chk({tag, ".cfg_n"}, ConfigBits_N, ~exp);
  endtask

  initial begin
    resetn      = 1'b0;
    FrameData   = '0;
    FrameStrobe = '0;
    CommitReq   = 1'b0;
    ClearErr    = 1'b0;
`ifdef READBACK_EN
    ReadReq     = 1'b0;
    ReadAddr    = '0;
`endif

    // Reset state
    step();
    chk_cfg("rst", '0);
    chk("rst.loaded", NCB'(FramesLoaded), '0);
    chk("rst.done",   NCB'(CommitDone),   '0);
    chk("rst.cerr",   NCB'(CommitErr),    '0);
    chk("rst.serr",   NCB'(StrobeErr),    '0);
`ifdef READBACK_EN
    chk("rst.rvalid", NCB'(ReadValid), '0);
    chk("rst.rdata",  NCB'(ReadData),  '0);
`endif
    resetn = 1'b1;
    step();

    // Full load then commit
    for (int f = 0; f < 5; f++) write_frame(f, 32'hA5A5_0000 + 32'(f));
    chk("load.loaded", NCB'(FramesLoaded), 160'h1F);
    chk_cfg("load.pre", '0);
    CommitReq = 1'b1;
    step();
    exp_cfg = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    chk("commit.done",   NCB'(CommitDone),   160'h1);
    chk("commit.cerr",   NCB'(CommitErr),    '0);
    chk("commit.lo",     NCB'(ConfigBits[31:0]),    160'hA5A5_0000);
    chk("commit.hi",     NCB'(ConfigBits[159:128]), 160'hA5A5_0004);
    chk_cfg("commit", exp_cfg);
    chk("commit.loaded", NCB'(FramesLoaded), '0);
    // Request held into DONE: ignored, no error
    step();
    CommitReq = 1'b0;
    chk("done.pulse", NCB'(CommitDone), '0);
    chk("done.cerr",  NCB'(CommitErr),  '0);
    chk_cfg("done", exp_cfg);

`ifdef READBACK_EN
    ReadReq = 1'b1; ReadAddr = 5'd4;
    step();
    chk("rb4.valid", NCB'(ReadValid), 160'h1);
    chk("rb4.data",  NCB'(ReadData),  160'hA5A5_0004);
    ReadAddr = 5'd7;
    step();
    ReadReq = 1'b0;
    chk("rb7.valid", NCB'(ReadValid), 160'h1);
    chk("rb7.data",  NCB'(ReadData),  '0);
    chk("rb7.serr",  NCB'(StrobeErr), 160'h1);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    chk("rb.clr.serr", NCB'(StrobeErr), '0);
    chk("rb.idle.valid", NCB'(ReadValid), '0);
`endif

    // Partial load: commit rejected
    for (int f = 0; f < 4; f++) write_frame(f, 32'h1111_0000 + 32'(f));
    CommitReq = 1'b1;
    step();
    CommitReq = 1'b0;
    chk("part.cerr",   NCB'(CommitErr),    160'h1);
    chk("part.done",   NCB'(CommitDone),   '0);
    chk("part.loaded", NCB'(FramesLoaded), 160'hF);
    chk_cfg("part", exp_cfg);
    step();
    chk("part.cerr.pulse", NCB'(CommitErr), '0);

    // Illegal strobes: multi-hot, then out-of-range one-hot with ClearErr (error wins)
    FrameStrobe = 32'h0000_0003; FrameData = 32'hDEAD_BEEF;
    step();
    chk("multi.serr",   NCB'(StrobeErr),    160'h1);
    chk("multi.loaded", NCB'(FramesLoaded), 160'hF);
    FrameStrobe = 32'h0000_0020; ClearErr = 1'b1;
    step();
    chk("oor.serr",   NCB'(StrobeErr),    160'h1);
    chk("oor.loaded", NCB'(FramesLoaded), 160'hF);
    FrameStrobe = '0; FrameData = '0;
    step();
    ClearErr = 1'b0;
    chk("clr.serr", NCB'(StrobeErr), '0);

    // Complete mask, then write + commit in the same cycle: commit dropped
    write_frame(4, 32'h2222_0004);
    chk("full.loaded", NCB'(FramesLoaded), 160'h1F);
    FrameStrobe = 32'h0000_0004; FrameData = 32'h3333_0002; CommitReq = 1'b1;
    step();
    FrameStrobe = '0; FrameData = '0; CommitReq = 1'b0;
    chk("coll.done", NCB'(CommitDone), '0);
    chk("coll.cerr", NCB'(CommitErr),  '0);
    chk("coll.serr", NCB'(StrobeErr),  '0);
    chk_cfg("coll", exp_cfg);
    // Retry commits the new frame 2; a same-edge readback sees the old bank
    CommitReq = 1'b1;
`ifdef READBACK_EN
    ReadReq = 1'b1; ReadAddr = 5'd2;
`endif
    step();
    CommitReq = 1'b0;
    exp_cfg = {32'h2222_0004, 32'h1111_0003, 32'h3333_0002, 32'h1111_0001, 32'h1111_0000};
    chk("retry.done", NCB'(CommitDone), 160'h1);
    chk_cfg("retry", exp_cfg);
    chk("retry.loaded", NCB'(FramesLoaded), '0);
`ifdef READBACK_EN
    chk("rbcommit.data", NCB'(ReadData), 160'hA5A5_0002);
    ReadReq = 1'b0;
    step();
    chk("rbhold.valid", NCB'(ReadValid), '0);
    chk("rbhold.data",  NCB'(ReadData),  160'hA5A5_0002);
`endif

    // Single-frame update after commit still needs a full mask
    step();
    write_frame(0, 32'h4444_0000);
    CommitReq = 1'b1;
    step();
    CommitReq = 1'b0;
    chk("upd.cerr",   NCB'(CommitErr),    160'h1);
    chk("upd.loaded", NCB'(FramesLoaded), 160'h1);
    chk_cfg("upd", exp_cfg);

    // Asynchronous reset between edges clears everything immediately
    FrameStrobe = 32'h0000_0010; FrameData = 32'h5555_5555;
    #2 resetn = 1'b0;
    #1;
    chk_cfg("arst", '0);
    chk("arst.loaded", NCB'(FramesLoaded), '0);
    FrameStrobe = '0; FrameData = '0;
    @(negedge CLK);
    resetn = 1'b1;
    step();
    CommitReq = 1'b1;
    step();
    CommitReq = 1'b0;
    chk("arst.cerr", NCB'(CommitErr), 160'h1);
    chk_cfg("arst.after", '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
